piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
Parallel-in, serial-out transmitter; the sending end of the n-bit serial link whose receiver shifts right (SI enters at MSB, word complete after n clocks).
Accepts one n-bit word per valid/ready handshake and emits it one bit per clock, LSB first by default.
With this bit order, a right-shifting receiver clocked on the same edges holds the original word after n bits.
Sits between a word-producing block and the serial line; SO_valid frames the bits on that line.

Parameters:
n, 4, word width in bits; legal range n >= 2.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset; clears all state immediately.
D  input  n  parallel word to transmit; sampled only on the accept edge.
load_valid  input  1  producer has a word on D.
load_ready  output  1  block can accept a word on this clock edge.
SO  output  1  serial data bit.
SO_valid  output  1  high exactly while SO carries a word bit.
done  output  1  one-cycle pulse after the last bit of a word.

Behaviour:
- State machine has two states: IDLE and SHIFT.
- Internal state: shift register sreg[n-1:0], bit counter cnt of width clog2(n), and the state.
- Reset (async, any time, including mid-word): state=IDLE, sreg=0, cnt=0, done=0.
- While rst is high: SO=0, SO_valid=0, load_ready=0.
- Outputs are driven from registers, or from state/cnt, only; no combinational path from D to SO.
  - SO = sreg[0] in SHIFT, 0 in IDLE.
  - SO_valid = (state==SHIFT).
  - load_ready = (state==IDLE) OR (state==SHIFT AND cnt==0), gated low by rst.
- Accept occurs on a rising edge with load_valid AND load_ready. On accept:
  - sreg <= D;
  - cnt <= n-1;
  - state <= SHIFT.
- Latency: the first bit (D[0]) appears on SO in the cycle after the accept edge.
- In SHIFT, each edge without accept: sreg <= {1'b0, sreg[n-1:1]} and cnt <= cnt-1.
- Last-bit edge (SHIFT, cnt==0):
  - without accept: state <= IDLE and done <= 1 for one cycle;
  - with accept: reload as above and stay in SHIFT, giving gapless back-to-back words; done still pulses for the finished word.
- done is 0 in every other cycle. done and the first bit of the next word may be high together.
- Word timing: SO_valid is high for exactly n consecutive cycles per word. Bit i of the word appears i cycles after the first bit.
- D and load_valid are ignored whenever load_ready=0. The producer holds load_valid until accepted; a word is never dropped or duplicated.
- cnt never wraps: it is only decremented while cnt>0 in SHIFT.

Optional Feature:
Macro PISO_MSB_FIRST_EN.
- Defined:
  - SO = sreg[n-1] in SHIFT;
  - shift is sreg <= {sreg[n-2:0], 1'b0};
  - D[n-1] is sent first.
  - This pairs with a left-shifting receiver. All timing, handshake and done behaviour are unchanged.
- Not defined: LSB-first, exactly as described in Behaviour.

Test Plan:
- Single word: after rst, n=4, D=4'b1011, load_valid pulsed for 1 cycle -> SO = 1,1,0,1 over 4 cycles with SO_valid high; done pulses in the 5th cycle; load_ready low during the first 3 bit cycles.
- Loopback: a right-shift receiver (n=4) is driven by SO on the same clk, sampled when done=1 -> receiver Q equals the sent word for 4'h0, 4'hF, 4'hA and 4'h5.
- Back-to-back: load_valid held high with 4'h3 then 4'hC -> 8 contiguous SO_valid cycles with SO = 1,1,0,0,0,0,1,1; done pulses once after the 4th bit and once after the 8th.
- Stall: load_valid kept low for 10 cycles after a word completes -> SO=0, SO_valid=0, load_ready=1, done=0 throughout; D toggling has no effect.
- Reset mid-word: rst asserted asynchronously (between edges) during the 2nd bit of 4'b0110 -> SO, SO_valid and done go to 0 immediately. After release, the next accept of 4'b1001 sends 1,0,0,1 with no residue from the old word.
- With PISO_MSB_FIRST_EN defined, D=4'b1011 -> SO = 1,0,1,1; timing is the same as in the single-word test.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter with valid/ready load handshake; LSB first by default.
// Define PISO_MSB_FIRST_EN to send D[n-1] first (pairs with a left-shifting receiver).
module piso_serializer #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [n-1:0] D,
  input  logic         load_valid,
  output logic         load_ready,
  output logic         SO,
  output logic         SO_valid,
  output logic         done
);

  localparam int CW = $clog2(n);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state;
  logic [n-1:0]  sreg;
  logic [CW-1:0] cnt;
  logic          ready_int;
  logic          accept;
  logic          last_bit;

  assign last_bit   = (state == SHIFT) && (cnt == '0);
  assign ready_int  = (state == IDLE) || last_bit;
  assign load_ready = ready_int && !rst;
  assign accept     = load_valid && ready_int;

  assign SO_valid = (state == SHIFT);
`ifdef PISO_MSB_FIRST_EN
  assign SO = (state == SHIFT) ? sreg[n-1] : 1'b0;
`else
  assign SO = (state == SHIFT) ? sreg[0] : 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      // A reload on the last-bit edge keeps consecutive words gapless.
      if (accept) begin
        sreg  <= D;
        cnt   <= CW'(n - 1);
        state <= SHIFT;
        if (last_bit) done <= 1'b1;
      end else if (state == SHIFT) begin
`ifdef PISO_MSB_FIRST_EN
        sreg <= {sreg[n-2:0], 1'b0};
`else
        sreg <= {1'b0, sreg[n-1:1]};
`endif
        if (cnt == '0) begin
          state <= IDLE;
          done  <= 1'b1;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed self-checking bench for piso_serializer (n=4): single word, loopback,
// back-to-back, stall and asynchronous mid-word reset.
module tb_piso_serializer;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] D;
  logic         load_valid;
  logic         load_ready;
  logic         SO;
  logic         SO_valid;
  logic         done;

  int total = 0;
  int bad   = 0;

  logic [N-1:0] rq;

  piso_serializer #(.n(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .D          (D),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .SO         (SO),
    .SO_valid   (SO_valid),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference receiver clocked on the same edges as the transmitter.
  always_ff @(posedge clk) begin
    if (SO_valid) begin
`ifdef PISO_MSB_FIRST_EN
      rq <= {rq[N-2:0], SO};
`else
      rq <= {SO, rq[N-1:1]};
`endif
    end
  end

  function automatic logic bit_at(input logic [N-1:0] w, input int i);
`ifdef PISO_MSB_FIRST_EN
    return w[N-1-i];
`else
    return w[i];
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [N-1:0] w;
    logic [N-1:0] lb_words [4];
    logic [N-1:0] b2b [2];
    int k;

    lb_words[0] = 4'h0; lb_words[1] = 4'hF; lb_words[2] = 4'hA; lb_words[3] = 4'h5;
    b2b[0] = 4'h3; b2b[1] = 4'hC;
    rq = '0;
    rst = 1'b1; D = '0; load_valid = 1'b0;

    // Reset state
    #2;
    chk("rst_so", 8'(SO), 8'h0);
    chk("rst_so_valid", 8'(SO_valid), 8'h0);
    chk("rst_ready", 8'(load_ready), 8'h0);
    chk("rst_done", 8'(done), 8'h0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("idle_ready", 8'(load_ready), 8'h1);
    chk("idle_so_valid", 8'(SO_valid), 8'h0);

    // Single word
    w = 4'b1011;
    D = w; load_valid = 1'b1;
    tick();
    load_valid = 1'b0; D = '0;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("single_so_%0d", i), 8'(SO), 8'(bit_at(w, i)));
      chk($sformatf("single_vld_%0d", i), 8'(SO_valid), 8'h1);
      chk($sformatf("single_rdy_%0d", i), 8'(load_ready), 8'(i == N - 1));
      chk($sformatf("single_done_%0d", i), 8'(done), 8'h0);
      tick();
    end
    chk("single_done_pulse", 8'(done), 8'h1);
    chk("single_vld_after", 8'(SO_valid), 8'h0);
    tick();
    chk("single_done_clear", 8'(done), 8'h0);

    // Loopback into the reference receiver
    for (int j = 0; j < 4; j++) begin
      D = lb_words[j]; load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      k = 0;
      while (!done && k < 20) begin
        tick();
        k++;
      end
      chk($sformatf("lb_done_%0d", j), 8'(done), 8'h1);
      chk($sformatf("lb_word_%0d", j), 8'(rq), 8'(lb_words[j]));
      tick();
    end

    // Back-to-back words with load_valid held
    D = b2b[0]; load_valid = 1'b1;
    tick();
    D = b2b[1];
    for (int i = 0; i < 2 * N; i++) begin
      chk($sformatf("b2b_vld_%0d", i), 8'(SO_valid), 8'h1);
      chk($sformatf("b2b_so_%0d", i), 8'(SO), 8'(bit_at(b2b[i / N], i % N)));
      chk($sformatf("b2b_done_%0d", i), 8'(done), 8'(i == N));
      tick();
      if (i == N - 1) load_valid = 1'b0;
    end
    chk("b2b_done_end", 8'(done), 8'h1);
    chk("b2b_vld_end", 8'(SO_valid), 8'h0);
    tick();

    // Stall: D toggles while no word is offered
    for (int i = 0; i < 10; i++) begin
      D = N'($urandom_range(0, 15));
      chk($sformatf("stall_so_%0d", i), 8'(SO), 8'h0);
      chk($sformatf("stall_vld_%0d", i), 8'(SO_valid), 8'h0);
      chk($sformatf("stall_rdy_%0d", i), 8'(load_ready), 8'h1);
      chk($sformatf("stall_done_%0d", i), 8'(done), 8'h0);
      tick();
    end

    // Asynchronous reset during the 2nd bit of 4'b0110
    w = 4'b0110;
    D = w; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    tick();
    chk("mid_so_before", 8'(SO), 8'(bit_at(w, 1)));
    #3;
    rst = 1'b1;
    #1;
    chk("mid_so", 8'(SO), 8'h0);
    chk("mid_vld", 8'(SO_valid), 8'h0);
    chk("mid_done", 8'(done), 8'h0);
    chk("mid_rdy", 8'(load_ready), 8'h0);
    tick();
    rst = 1'b0;
    w = 4'b1001;
    D = w; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("post_so_%0d", i), 8'(SO), 8'(bit_at(w, i)));
      chk($sformatf("post_vld_%0d", i), 8'(SO_valid), 8'h1);
      tick();
    end
    chk("post_done", 8'(done), 8'h1);
    chk("post_word", 8'(rq), 8'(w));
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
